// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/glyph ROM between NUM_REQ pixel requesters.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 (VGA scan path) strict priority.

module sprite_rom_arbiter_lane #(
    parameter int ROM_LAT = 1
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic issue,
    output logic tag_last,
    output logic rd_valid
);
    // vld_pipe[ROM_LAT-1:0] is the in-flight tag, vld_pipe[ROM_LAT] the registered return strobe.
    logic [ROM_LAT:0] vld_pipe;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[ROM_LAT-1:0], issue};
    end

    assign tag_last = vld_pipe[ROM_LAT-1];
    assign rd_valid = vld_pipe[ROM_LAT];
endmodule

module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                           state;
    logic [PTR_W-1:0]                 rr_ptr;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_vec;
    logic [NUM_REQ-1:0]               eligible, pool, gnt_nxt, tag_last;
    logic [PTR_W:0]                   idx;
    logic [PTR_W-1:0]                 winner, rr_next;
    logic                             found, any_elig, adv;

    assign addr_vec = req_addr;
    assign rom_en   = (state == ISSUE);

    always_comb begin
        // A requester already holding gnt is masked so a held req is not granted twice in a row.
        eligible = req & ~gnt;
        any_elig = |eligible;
        pool     = eligible;
`ifdef SPRITE_ARB_PRIO0_EN
        pool[0]  = 1'b0;
`endif
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && pool[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
        adv = found;
`ifdef SPRITE_ARB_PRIO0_EN
        // Scan path pre-empts the rotation and leaves the pointer where it was.
        if (eligible[0]) begin
            winner = '0;
            adv    = 1'b0;
        end
`endif
        rr_next = (winner == LAST) ? '0 : winner + PTR_W'(1);
        gnt_nxt = '0;
        if (any_elig) gnt_nxt[winner] = 1'b1;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt         <= '0;
            rom_address <= '0;
            rr_ptr      <= '0;
        end else if (any_elig) begin
            state       <= ISSUE;
            gnt         <= gnt_nxt;
            rom_address <= addr_vec[winner];
            if (adv) rr_ptr <= rr_next;
        end else begin
            state       <= IDLE;
            gnt         <= '0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_REQ; i++) begin : g_lane
            sprite_rom_arbiter_lane #(.ROM_LAT(ROM_LAT)) u_lane (
                .vga_clk  (vga_clk),
                .reset_n  (reset_n),
                .issue    (gnt[i]),
                .tag_last (tag_last[i]),
                .rd_valid (rd_valid[i])
            );
        end
    endgenerate

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)       rd_data <= '0;
        else if (|tag_last) rd_data <= rom_q;
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: ROM_LAT=1 main instance plus a ROM_LAT=2 instance.
// Build with SPRITE_ARB_PRIO0_EN defined to exercise the priority scenario instead of the wrap one.

module tb_sprite_rom_arbiter;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 4;

    logic             vga_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NR-1:0]    req   = '0, req_b = '0;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    gnt, rd_valid, gnt_b, rd_valid_b;
    logic [DW-1:0]    rd_data, rd_data_b, rom_q, rom_q_b, qb0;
    logic             rom_en, rom_en_b;
    logic [AW-1:0]    rom_address, rom_address_b;
    logic [AW-1:0]    addr_tab [NR];

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ {2'b10, a[9:8]};
    endfunction

    // Synchronous ROM models: 1 and 2 cycles of latency.
    always_ff @(posedge vga_clk) begin
        rom_q   <= rom_word(rom_address);
        qb0     <= rom_word(rom_address_b);
        rom_q_b <= qb0;
    end

    sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rom_en(rom_en),
        .rom_address(rom_address), .rom_q(rom_q)
    );

    sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req_b), .req_addr(req_addr),
        .gnt(gnt_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rom_en(rom_en_b),
        .rom_address(rom_address_b), .rom_q(rom_q_b)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        total++;
        if ({gnt, rd_valid, rd_data, rom_en, rom_address} !== '0) begin
            bad++; $display("FAIL reset_idle gnt=%b rv=%b data=%h en=%b addr=%h exp all 0",
                            gnt, rd_valid, rd_data, rom_en, rom_address);
        end
        reset_n = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        total++;
        if (rom_en !== 1'b1) begin
            bad++; $display("FAIL reset_burst_en got=%b exp=1", rom_en);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({gnt, rd_valid, rd_data, rom_en, rom_address} !== '0) begin
            bad++; $display("FAIL reset_async gnt=%b rv=%b data=%h en=%b addr=%h exp all 0",
                            gnt, rd_valid, rd_data, rom_en, rom_address);
        end
        req = '0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (rd_valid !== '0 || gnt !== '0) begin
                bad++; $display("FAIL reset_release c%0d rv=%b gnt=%b exp 0", k, rd_valid, gnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] eg [6];
        logic [NR-1:0] ev [6];
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        ev = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (gnt !== eg[k]) begin
                bad++; $display("FAIL b2b_gnt c%0d got=%b exp=%b", k, gnt, eg[k]);
            end
            total++;
            if (rd_valid !== ev[k]) begin
                bad++; $display("FAIL b2b_rv c%0d got=%b exp=%b", k, rd_valid, ev[k]);
            end
            if (k >= 2) begin
                total++;
                if (rd_data !== rom_word(addr_tab[k-2])) begin
                    bad++; $display("FAIL b2b_data c%0d got=%h exp=%h", k, rd_data,
                                    rom_word(addr_tab[k-2]));
                end
            end
            req = req & ~gnt;
        end
    endtask

    task automatic test_single();
        logic [NR-1:0] eg [4];
        logic [NR-1:0] ev [4];
        eg = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        ev = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (gnt !== eg[k] || rom_en !== eg[k][0]) begin
                bad++; $display("FAIL single_gnt c%0d got=%b/%b exp=%b", k, gnt, rom_en, eg[k]);
            end
            total++;
            if (rd_valid !== ev[k]) begin
                bad++; $display("FAIL single_rv c%0d got=%b exp=%b", k, rd_valid, ev[k]);
            end
            if (k == 0) begin
                total++;
                if (rom_address !== 10'h123) begin
                    bad++; $display("FAIL single_addr got=%h exp=123", rom_address);
                end
            end
            if (k == 2) begin
                total++;
                if (rd_data !== rom_word(10'h123)) begin
                    bad++; $display("FAIL single_data got=%h exp=%h", rd_data, rom_word(10'h123));
                end
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

`ifndef SPRITE_ARB_PRIO0_EN
    task automatic test_wrap();
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100) begin
            bad++; $display("FAIL wrap_prep got=%b exp=0100", gnt);
        end
        req = '0;
        tick();
        req = 4'b1001;
        tick();
        total++;
        if (gnt !== 4'b1000 || rom_address !== addr_tab[3]) begin
            bad++; $display("FAIL wrap_first got=%b/%h exp=1000/%h", gnt, rom_address, addr_tab[3]);
        end
        req = 4'b0001;
        tick();
        total++;
        if (gnt !== 4'b0001 || rom_address !== addr_tab[0]) begin
            bad++; $display("FAIL wrap_second got=%b/%h exp=0001/%h", gnt, rom_address, addr_tab[0]);
        end
        req = 4'b0011;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++; $display("FAIL wrap_ptr got=%b exp=0010", gnt);
        end
        req = '0;
        repeat (3) tick();
    endtask
`else
    task automatic test_prio0();
        logic [NR-1:0] eg [8];
        eg = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0001, 4'b0000};
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (gnt !== eg[k]) begin
                bad++; $display("FAIL prio_gnt c%0d got=%b exp=%b", k, gnt, eg[k]);
            end
            if (k >= 2) begin
                total++;
                if (rd_valid !== eg[k-2]) begin
                    bad++; $display("FAIL prio_rv c%0d got=%b exp=%b", k, rd_valid, eg[k-2]);
                end
            end
            req = req & ~(gnt & 4'b1110);
            if (k == 6) req = '0;
        end
        repeat (3) tick();
    endtask
`endif

    task automatic test_lat2();
        req_b = 4'b0110;
        tick();
        total++;
        if (gnt_b !== 4'b0010 || rom_address_b !== addr_tab[1]) begin
            bad++; $display("FAIL lat2_gnt1 got=%b/%h exp=0010/%h", gnt_b, rom_address_b, addr_tab[1]);
        end
        req_b = 4'b0100;
        tick();
        total++;
        if (gnt_b !== 4'b0100 || rom_address_b !== addr_tab[2]) begin
            bad++; $display("FAIL lat2_gnt2 got=%b/%h exp=0100/%h", gnt_b, rom_address_b, addr_tab[2]);
        end
        req_b = '0;
        tick();
        total++;
        if (rd_valid_b !== 4'b0000) begin
            bad++; $display("FAIL lat2_early got=%b exp=0000", rd_valid_b);
        end
        tick();
        total++;
        if (rd_valid_b !== 4'b0010 || rd_data_b !== rom_word(addr_tab[1])) begin
            bad++; $display("FAIL lat2_ret1 got=%b/%h exp=0010/%h", rd_valid_b, rd_data_b,
                            rom_word(addr_tab[1]));
        end
        tick();
        total++;
        if (rd_valid_b !== 4'b0100 || rd_data_b !== rom_word(addr_tab[2])) begin
            bad++; $display("FAIL lat2_ret2 got=%b/%h exp=0100/%h", rd_valid_b, rd_data_b,
                            rom_word(addr_tab[2]));
        end
        tick();
        total++;
        if (rd_valid_b !== 4'b0000) begin
            bad++; $display("FAIL lat2_tail got=%b exp=0000", rd_valid_b);
        end
    endtask

    initial begin
        addr_tab = '{10'h123, 10'h2A5, 10'h0F0, 10'h3C6};
        req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        test_reset();
        test_back_to_back();
        test_single();
`ifndef SPRITE_ARB_PRIO0_EN
        test_wrap();
`else
        test_prio0();
`endif
        test_lat2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
